factorial_seq: RTL and testbench
================================

Name: factorial_seq

Overview:
Multi-cycle iterative factorial / double-factorial engine with a start/done handshake. It replaces single-cycle combinational factorial evaluation with one multiply per clock, parametrised in operand and result widths. Overflow is flagged, not silently wrapped. It sits behind control logic that issues one operand at a time and waits for done.

Parameters:
N_W, 4, width of operand n
RES_W, 32, width of result accumulator

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; accepted only in IDLE
n  input  N_W  operand, sampled on accepted start
dbl  input  1  mode, sampled on accepted start; 0 = n!, 1 = n!!
busy  output  1  high while computing (MUL state)
done  output  1  one-cycle completion pulse (DONE state)
result  output  RES_W  low RES_W bits of the computed product
overflow  output  1  true product exceeded RES_W bits

Behaviour:
- One clock, clk. Reset is synchronous and active-high, named reset.
- Reset (any state, including mid-operation): state=IDLE, busy=0, done=0, result=0, overflow=0. An in-flight operation is aborted with no done pulse.
- States:
  - IDLE: if start=1, latch i=n, step=dbl?2:1, acc=1, ovf=0, then go to MUL. Otherwise stay.
  - MUL: if i<=1, go to DONE. Else:
    - full product p=acc*i, width RES_W+N_W;
    - acc=p[RES_W-1:0];
    - ovf|=|p[RES_W+N_W-1:RES_W];
    - i=i-step.
    - Guard the subtraction with the i<=1 check; for dbl, i=2 gives i=0, which exits on the next cycle.
  - DONE: done=1 for exactly this cycle; then go to IDLE.
- result and overflow load from acc/ovf on the MUL->DONE transition. They hold that value until the next completion or reset, and do not change during a computation.
- busy=1 exactly in MUL cycles. done=1 exactly in the DONE cycle. busy and done are never both 1.
- Definitions: 0!=1!=1; 0!!=1!!=1. Factors are multiplied in descending order.
- Latency: start accepted at cycle T gives done at T+1+M.
  - M = max(n,1) for n!.
  - M = floor(n/2)+1 for n!!.
- start while busy or in DONE is ignored (not queued). start and n/dbl changes after acceptance have no effect.
- Overflow is sticky within one operation only and clears on the next accepted start.
- n is unsigned, full N_W range legal (n=2^N_W-1 must work).

Test Plan:
- Reset asserted 2 cycles, then start with n=5, dbl=0 at cycle T -> busy high T+1..T+5; done pulse at T+6; result=120; overflow=0. Result stays 120 until next done.
- n=0, dbl=0 and n=1, dbl=1 -> done at T+2 in both cases; result=1; overflow=0.
- dbl=1 with n=7 -> 105 (done T+5); n=8 -> 384 (done T+6); n=15 -> 2027025, overflow=0.
- RES_W=32: n=12 -> 479001600, overflow=0. Then n=13 -> result=1932053504, overflow=1. Then n=3 -> 6, overflow=0 (sticky clears).
- start pulsed again at T+3 during an n=5 run with n=2 -> ignored; done at T+6 with 120. Second start on the done cycle is also ignored.
- reset asserted at T+3 of an n=10 run -> next cycle busy=0, done=0, result=0. No done pulse follows. A fresh start with n=4 -> 24.

Source files
------------

// File: rtl/factorial_seq.sv
// ---------------------------------------------------------------------------
// factorial_seq
//
// Multi-cycle iterative factorial / double-factorial engine. One multiply is
// performed per clock while busy. The running product is kept to RES_W bits,
// and any bits that fall off the top are recorded in a sticky overflow flag
// that lasts for one operation.
//
// Ports:
//   clk      : system clock, all logic on the rising edge
//   reset    : synchronous, active-high reset (aborts any operation)
//   start    : request, accepted only while idle
//   n        : operand (unsigned), sampled when start is accepted
//   dbl      : mode, sampled when start is accepted; 0 = n!, 1 = n!!
//   busy     : high during every multiply cycle
//   done     : one-cycle completion pulse
//   result   : low RES_W bits of the product, held until the next completion
//   overflow : the true product did not fit in RES_W bits
// ---------------------------------------------------------------------------
module factorial_seq #(
    parameter int N_W   = 4,
    parameter int RES_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [N_W-1:0]   n,
    input  logic             dbl,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] result,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [N_W-1:0]       i_cnt;
    logic [N_W-1:0]       step;
    logic [RES_W-1:0]     acc;
    logic                 ovf;
    logic [RES_W+N_W-1:0] prod;
    logic                 last;

    // Once the factor drops to 1 or 0 there is nothing left to multiply.
    // Checking this before subtracting keeps i_cnt from wrapping when a
    // double factorial steps from 2 down to 0.
    assign last = (i_cnt <= N_W'(1));

    // Full-width product so that bits beyond RES_W can be seen for overflow.
    assign prod = {{N_W{1'b0}}, acc} * {{RES_W{1'b0}}, i_cnt};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = MUL;
                end
            end
            MUL: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Working registers: these are fully reloaded on every accepted start,
    // so they need no reset.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    i_cnt <= n;
                    step  <= dbl ? N_W'(2) : N_W'(1);
                    acc   <= RES_W'(1);
                    ovf   <= 1'b0;
                end
            end
            MUL: begin
                if (!last) begin
                    acc   <= prod[RES_W-1:0];
                    ovf   <= ovf | (|prod[RES_W+N_W-1:RES_W]);
                    i_cnt <= i_cnt - step;
                end
            end
            default: begin
            end
        endcase
    end

    // Visible result: updated only as the multiply loop finishes, so it
    // never shows partial products.
    always_ff @(posedge clk) begin
        if (reset) begin
            result   <= '0;
            overflow <= 1'b0;
        end else if (state == MUL && last) begin
            result   <= acc;
            overflow <= ovf;
        end
    end

endmodule

// File: tb/tb_factorial_seq.sv
module tb_factorial_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  n_in;
    logic        dbl_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;

    factorial_seq #(.N_W(4), .RES_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .n        (n_in),
        .dbl      (dbl_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter; stable when sampled on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        int          done_cyc;
        int          m;
    } exp_t;

    exp_t sb[$];

    int total  = 0;
    int passed = 0;
    int busy_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: pop an expectation whenever the DUT signals completion.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            busy_cnt = 0;
        end else begin
            if (busy && done) chk("busy_and_done", 1, 0);
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("result",      result,   e.res);
                    chk("overflow",    overflow, e.ovf);
                    chk("done_cycle",  cyc,      e.done_cyc);
                    chk("busy_cycles", busy_cnt, e.m);
                end
                busy_cnt = 0;
            end
        end
    end

    // Drive start for one cycle; returns at the falling edge after acceptance.
    task automatic issue(input logic [3:0] nv, input logic dv, input logic [31:0] res,
                         input logic ov, input int m, input bit push, output int acc_edge);
        @(negedge clk);
        start  = 1'b1;
        n_in   = nv;
        dbl_in = dv;
        acc_edge = cyc + 1;
        if (push) sb.push_back('{res, ov, acc_edge + m, m});
        @(negedge clk);
        start  = 1'b0;
        n_in   = ~nv;
        dbl_in = ~dv;
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    typedef struct {
        logic [3:0]  nv;
        logic        dv;
        logic [31:0] res;
        logic        ov;
        int          m;
    } vec_t;

    vec_t vecs[9] = '{
        '{4'd13, 1'b0, 32'd1932053504, 1'b1, 13},
        '{4'd3,  1'b0, 32'd6,          1'b0, 3},
        '{4'd0,  1'b0, 32'd1,          1'b0, 1},
        '{4'd1,  1'b1, 32'd1,          1'b0, 1},
        '{4'd7,  1'b1, 32'd105,        1'b0, 4},
        '{4'd8,  1'b1, 32'd384,        1'b0, 5},
        '{4'd15, 1'b1, 32'd2027025,    1'b0, 8},
        '{4'd1,  1'b0, 32'd1,          1'b0, 1},
        '{4'd2,  1'b1, 32'd2,          1'b0, 2}
    };

    initial begin
        int a;
        reset  = 1'b1;
        start  = 1'b0;
        n_in   = '0;
        dbl_in = 1'b0;

        // Reset held for two cycles
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy",     busy,     0);
        chk("rst_done",     done,     0);
        chk("rst_result",   result,   0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b0;

        // 5! then 12!, checking result holds 120 during the 12! run
        issue(4'd5, 1'b0, 32'd120, 1'b0, 5, 1, a);
        wait_drain();
        issue(4'd12, 1'b0, 32'd479001600, 1'b0, 12, 1, a);
        chk("hold_120_a", result, 120);
        repeat (5) @(negedge clk);
        chk("hold_120_b", result, 120);
        chk("busy_mid",   busy,   1);
        wait_drain();

        // Overflow, sticky clear, edge operands, double factorials
        foreach (vecs[k]) begin
            issue(vecs[k].nv, vecs[k].dv, vecs[k].res, vecs[k].ov, vecs[k].m, 1, a);
            wait_drain();
        end

        // Starts during busy and on the done cycle are ignored
        issue(4'd5, 1'b0, 32'd120, 1'b0, 5, 1, a);
        @(negedge clk);
        start = 1'b1; n_in = 4'd2; dbl_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (cyc < a + 5) @(negedge clk);
        chk("done_visible", done, 1);
        start = 1'b1; n_in = 4'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("ign_idle_busy", busy, 0);
        chk("ign_queue",     sb.size(), 0);
        chk("ign_result",    result, 120);

        // Reset mid-operation aborts without a done pulse
        issue(4'd10, 1'b0, 32'd0, 1'b0, 10, 0, a);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy",     busy,     0);
        chk("abort_done",     done,     0);
        chk("abort_result",   result,   0);
        chk("abort_overflow", overflow, 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_idle", busy, 0);
        issue(4'd4, 1'b0, 32'd24, 1'b0, 4, 1, a);
        wait_drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
